// File: rtl/digit_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_subtractor_if
// Purpose  : Operand/result handshake bundle for digit_serial_subtractor.
//            The ovf member exists only when DIGIT_SERIAL_SUB_OVERFLOW_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface digit_serial_subtractor_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bi;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] d;
    logic         bo;
    logic         zero;
    logic         busy;
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
    logic         ovf;

    modport master (
        output in_valid, a, b, bi, out_ready,
        input  in_ready, out_valid, d, bo, zero, busy, ovf
    );

    modport slave (
        input  in_valid, a, b, bi, out_ready,
        output in_ready, out_valid, d, bo, zero, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, bi, out_ready,
        input  in_ready, out_valid, d, bo, zero, busy
    );

    modport slave (
        input  in_valid, a, b, bi, out_ready,
        output in_ready, out_valid, d, bo, zero, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/digit_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_subtractor
// Purpose  : d = a - b - bi over N bits, W bits per clock, borrow chained
//            through a carry register. Optional macro: DIGIT_SERIAL_SUB_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module digit_serial_subtractor #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    digit_serial_subtractor_if.slave   bus
);

    localparam int c_num_digits = N / W;
    localparam int c_cnt_w      = (c_num_digits > 1) ? $clog2(c_num_digits) : 1;
    localparam logic [c_cnt_w-1:0] c_last_digit = c_cnt_w'(c_num_digits - 1);

    if ((W < 1) || (W > N)) begin : g_bad_digit_width
        $error("digit_serial_subtractor: W must satisfy 1 <= W <= N");
    end else if ((N % W) != 0) begin : g_bad_divisor
        $error("digit_serial_subtractor: N must be a multiple of W");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [N-1:0]         r_a;
    logic [N-1:0]         r_b;
    logic                 r_carry;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_all_zero;
    logic [N-1:0]         r_d;
    logic                 r_bo;
    logic                 r_zero;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
    logic                 r_ovf;
`endif

    logic [W-1:0]         w_a_dig;
    logic [W-1:0]         w_b_dig;
    logic [W:0]           w_sum;
    logic                 w_dig_zero;

    // Subtraction as a + ~b + carry; the carry register holds the inverted borrow.
    always_comb begin
        w_a_dig    = r_a[int'(r_cnt) * W +: W];
        w_b_dig    = r_b[int'(r_cnt) * W +: W];
        w_sum      = {1'b0, w_a_dig} + {1'b0, ~w_b_dig} + {{W{1'b0}}, r_carry};
        w_dig_zero = (w_sum[W-1:0] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_all_zero  <= 1'b0;
            r_d         <= '0;
            r_bo        <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_carry    <= ~bus.bi;
                        r_cnt      <= '0;
                        r_all_zero <= 1'b1;
                        r_state    <= S_BUSY;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    r_d[int'(r_cnt) * W +: W] <= w_sum[W-1:0];
                    r_carry    <= w_sum[W];
                    r_all_zero <= r_all_zero & w_dig_zero;
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == c_last_digit) begin
                        r_bo        <= ~w_sum[W];
                        r_zero      <= r_all_zero & w_dig_zero;
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
                        // The top digit's MSB is the result sign bit d[N-1].
                        r_ovf       <= (r_a[N-1] != r_b[N-1]) && (w_sum[W-1] != r_a[N-1]);
`endif
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.d         = r_d;
    assign bus.bo        = r_bo;
    assign bus.zero      = r_zero;
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_serial_subtractor
// Purpose  : Self-checking bench for W=8, W=32 and W=1 builds of the subtractor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_serial_subtractor;

    localparam int N = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    digit_serial_subtractor_if #(.N(N)) if8  ();
    digit_serial_subtractor_if #(.N(N)) if32 ();
    digit_serial_subtractor_if #(.N(N)) if1  ();

    digit_serial_subtractor #(.N(N), .W(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    digit_serial_subtractor #(.N(N), .W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    digit_serial_subtractor #(.N(N), .W(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;

    typedef struct {
        logic        ov;
        logic        ir;
        logic        busy;
        logic [31:0] d;
        logic        bo;
        logic        zero;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        logic [31:0] exp_d;
        logic        exp_bo;
        logic        exp_zero;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_in(input int sel, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic bi);
        case (sel)
            8:  begin if8.in_valid  = v; if8.a  = a; if8.b  = b; if8.bi  = bi; end
            32: begin if32.in_valid = v; if32.a = a; if32.b = b; if32.bi = bi; end
            default: begin if1.in_valid = v; if1.a = a; if1.b = b; if1.bi = bi; end
        endcase
    endtask

    task automatic drive_ordy(input int sel, input logic r);
        case (sel)
            8:       if8.out_ready  = r;
            32:      if32.out_ready = r;
            default: if1.out_ready  = r;
        endcase
    endtask

    task automatic sample(input int sel, output res_t r);
        r.ovf = 1'b0;
        case (sel)
            8: begin
                r.ov = if8.out_valid; r.ir = if8.in_ready; r.busy = if8.busy;
                r.d = if8.d; r.bo = if8.bo; r.zero = if8.zero;
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
                r.ovf = if8.ovf;
`endif
            end
            32: begin
                r.ov = if32.out_valid; r.ir = if32.in_ready; r.busy = if32.busy;
                r.d = if32.d; r.bo = if32.bo; r.zero = if32.zero;
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
                r.ovf = if32.ovf;
`endif
            end
            default: begin
                r.ov = if1.out_valid; r.ir = if1.in_ready; r.busy = if1.busy;
                r.d = if1.d; r.bo = if1.bo; r.zero = if1.zero;
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
                r.ovf = if1.ovf;
`endif
            end
        endcase
    endtask

    // Reference: whole-word subtraction with one extra bit to expose the borrow.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bi,
                         output logic [31:0] d, output logic bo, output logic zero,
                         output logic ovf);
        logic [32:0] full;
        full = {1'b0, a} - {1'b0, b} - {32'd0, bi};
        d    = full[31:0];
        bo   = full[32];
        zero = (d == 32'd0);
        ovf  = (a[31] != b[31]) && (d[31] != a[31]);
    endtask

    // Returns at the first falling edge after the accepting rising edge.
    task automatic accept(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic bi);
        res_t r;
        int   n;
        @(negedge clk);
        drive_in(sel, 1'b1, a, b, bi);
        sample(sel, r);
        n = 0;
        while (!r.ir && n < 200) begin
            @(negedge clk);
            sample(sel, r);
            n++;
        end
        check("in_ready_before_accept", {63'd0, r.ir}, 64'd1);
        @(negedge clk);
        drive_in(sel, 1'b0, a, b, bi);
    endtask

    task automatic wait_result(input int sel, output int lat, output res_t r);
        lat = 0;
        sample(sel, r);
        while (!r.ov && lat < 100) begin
            @(negedge clk);
            lat++;
            sample(sel, r);
        end
    endtask

    task automatic release_out(input int sel);
        drive_ordy(sel, 1'b1);
        @(negedge clk);
        drive_ordy(sel, 1'b0);
    endtask

    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic bi, input logic [31:0] exp_d, input logic exp_bo,
                          input logic exp_zero, input logic exp_ovf, input int exp_lat);
        res_t r;
        int   lat;
        accept(sel, a, b, bi);
        wait_result(sel, lat, r);
        check("latency", 64'(lat), 64'(exp_lat));
        check("out_valid", {63'd0, r.ov}, 64'd1);
        check("d", {32'd0, r.d}, {32'd0, exp_d});
        check("bo", {63'd0, r.bo}, {63'd0, exp_bo});
        check("zero", {63'd0, r.zero}, {63'd0, exp_zero});
`ifdef DIGIT_SERIAL_SUB_OVERFLOW_EN
        check("ovf", {63'd0, r.ovf}, {63'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) $display("unexpected X in expected ovf");
`endif
        release_out(sel);
    endtask

    task automatic run_random(input int sel, input int count, input int exp_lat);
        logic [31:0] a, b, ed;
        logic        bi, ebo, ez, eov;
        for (int i = 0; i < count; i++) begin
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a + 32'd1;
                default: b = $urandom;
            endcase
            bi = 1'($urandom_range(0, 1));
            model(a, b, bi, ed, ebo, ez, eov);
            run_op(sel, a, b, bi, ed, ebo, ez, eov, exp_lat);
        end
    endtask

    vec_t vecs[6];
    res_t rr;
    int   lat;
    int   sels[3];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'd5,          32'd3,          1'b0, 32'd2,          1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'd10,         32'd9,          1'b1, 32'd0,          1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'd10,         32'd10,         1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  1'b1, 1'b0, 1'b1};
        sels[0] = 8; sels[1] = 32; sels[2] = 1;

        n_checks = 0;
        n_errors = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        for (int s = 0; s < 3; s++) begin
            drive_in(sels[s], 1'b0, 32'd0, 32'd0, 1'b0);
            drive_ordy(sels[s], 1'b0);
        end

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sample(sels[s], rr);
            check("reset_in_ready", {63'd0, rr.ir}, 64'd1);
            check("reset_out_valid", {63'd0, rr.ov}, 64'd0);
            check("reset_busy", {63'd0, rr.busy}, 64'd0);
            check("reset_d", {32'd0, rr.d}, 64'd0);
            check("reset_bo_zero_ovf", {61'd0, rr.bo, rr.zero, rr.ovf}, 64'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op(8, vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].exp_d,
                   vecs[i].exp_bo, vecs[i].exp_zero, vecs[i].exp_ovf, 4);

        // Backpressure: result held for 5 cycles while a second offer is ignored.
        accept(8, 32'd100, 32'd1, 1'b0);
        wait_result(8, lat, rr);
        check("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 5; i++) begin
            sample(8, rr);
            check("bp_out_valid", {63'd0, rr.ov}, 64'd1);
            check("bp_d", {32'd0, rr.d}, 64'd99);
            check("bp_bo", {63'd0, rr.bo}, 64'd0);
            check("bp_in_ready", {63'd0, rr.ir}, 64'd0);
            if (i == 1) drive_in(8, 1'b1, 32'd50, 32'd20, 1'b0);
            if (i == 2) drive_in(8, 1'b0, 32'd50, 32'd20, 1'b0);
            @(negedge clk);
        end
        drive_ordy(8, 1'b1);
        drive_in(8, 1'b1, 32'd50, 32'd20, 1'b0);
        @(negedge clk);
        sample(8, rr);
        check("bp_release_out_valid", {63'd0, rr.ov}, 64'd0);
        check("bp_release_in_ready", {63'd0, rr.ir}, 64'd1);
        check("bp_release_busy", {63'd0, rr.busy}, 64'd0);
        drive_ordy(8, 1'b0);
        @(negedge clk);
        drive_in(8, 1'b0, 32'd0, 32'd0, 1'b0);
        sample(8, rr);
        check("bp_second_busy", {63'd0, rr.busy}, 64'd1);
        check("bp_second_in_ready", {63'd0, rr.ir}, 64'd0);
        wait_result(8, lat, rr);
        check("bp_second_latency", 64'(lat), 64'd4);
        check("bp_second_d", {32'd0, rr.d}, 64'd30);
        release_out(8);

        // Asynchronous reset in the middle of digit processing.
        accept(8, 32'h1234_5678, 32'd1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 sample(8, rr);
        check("async_rst_in_ready", {63'd0, rr.ir}, 64'd1);
        check("async_rst_out_valid", {63'd0, rr.ov}, 64'd0);
        check("async_rst_busy", {63'd0, rr.busy}, 64'd0);
        check("async_rst_d", {32'd0, rr.d}, 64'd0);
        check("async_rst_bo_zero_ovf", {61'd0, rr.bo, rr.zero, rr.ovf}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            sample(8, rr);
            check("post_rst_no_out_valid", {63'd0, rr.ov}, 64'd0);
        end
        run_op(8, 32'd7, 32'd7, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 4);

        run_random(8, 100, 4);

        run_op(32, 32'd100, 32'd1, 1'b0, 32'd99, 1'b0, 1'b0, 1'b0, 1);
        run_random(32, 50, 1);

        run_random(1, 1000, 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
